lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Load/store unit between the CPU core data port and the word-organised data RAM.
- Accepts one byte-addressed RV32I load/store request at a time; decodes funct3.
- Sub-word stores are done by read-modify-write on the 32-bit RAM; load data is sign- or zero-extended.
- Misaligned and illegal accesses are flagged without touching memory.

Parameters:
ADDR_W, 10, word-address width of the RAM port; byte address bits [ADDR_W+1:2] select the word, higher bits are ignored (wrap).

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  unit idle, request accepted when req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010)
req_addr  in  32  byte address
req_wdata  in  32  store data, low bits used for SB/SH
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_misaligned  out  1  valid with rsp_valid: alignment fault
rsp_error  out  1  valid with rsp_valid: illegal funct3
MemRead  out  1  RAM read strobe
MemWrite  out  1  RAM write strobe
address  out  ADDR_W  RAM word address
write_data  out  32  RAM write word
read_data  in  32  RAM read word, valid the cycle after MemRead is high

Behaviour:
- Reset (async, RSTn=0): state IDLE; req_ready=1; rsp_valid, rsp_misaligned, rsp_error, MemRead, MemWrite = 0; rsp_rdata, address, write_data = 0.
- FSM states: IDLE, RD, CAP, WR, RSP.
- MemRead=1 only in RD and MemWrite=1 only in WR (Moore outputs).
- req_ready=1 only in IDLE.
- address and write_data are registered.
- Request fields are latched on acceptance; the core may change them afterwards.
- IDLE, on accept:
  - Illegal funct3 (load 011/11x; store other than 000/001/010) -> RSP with rsp_error=1.
  - Misaligned (H: addr[0]≠0; W: addr[1:0]≠0) -> RSP with rsp_misaligned=1.
  - Error has priority over misaligned; no RAM strobe is issued for either.
  - LW/LB/LH/LBU/LHU and SB/SH -> RD.
  - SW -> WR, with write_data=req_wdata.
- RD -> CAP.
- CAP samples read_data:
  - Load: extract byte/halfword selected by addr[1:0]/addr[1], extend per funct3, register into rsp_rdata, go to RSP.
  - SB/SH: merge store bytes into the read word at their lane, load into write_data, go to WR.
- WR -> RSP.
- RSP: rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_rdata, rsp_misaligned and rsp_error hold until the next response.
  - No backpressure: the core must take the response.
- Latency (accept edge = cycle 0):
  - error/misaligned: rsp_valid in cycle 1
  - SW: MemWrite in cycle 1, rsp_valid in cycle 2
  - loads: MemRead in cycle 1, rsp_valid in cycle 3
  - SB/SH: MemRead c1, capture c2, MemWrite c3, rsp_valid c4
- Back-to-back: the next request is accepted in the cycle after RSP.
- Reset mid-operation: all strobes drop immediately (combinationally from state); a pending write is abandoned and RAM is not written. A partial RMW leaves RAM unmodified.

Test Plan:
1. SW addr 0x10, wdata 0xDEADBEEF -> c1: MemWrite=1, address=4, write_data=0xDEADBEEF; c2: rsp_valid=1, flags 0; RAM[4]=0xDEADBEEF.
2. RAM[4]=0x80FF7F01:
   - LB 0x13 -> rsp_rdata 0xFFFFFF80 at c3
   - LBU 0x13 -> 0x00000080
   - LB 0x10 -> 0x00000001
3. RAM[4]=0x80FF7F01:
   - LH 0x12 -> 0xFFFF80FF
   - LHU 0x12 -> 0x000080FF
   - LH 0x10 -> 0x00007F01
4. RAM[4]=0x11223344:
   - SB 0x11, wdata 0x000000AA -> c3 write_data=0x1122AA44, rsp at c4
   - then SH 0x12, wdata 0xBEEF -> RAM[4]=0xBEEFAA44
5. LW 0x06 -> no MemRead/MemWrite, c1 rsp_valid=1, rsp_misaligned=1, rsp_rdata=0.
   - Load funct3 011 -> rsp_error=1.
   - SH 0x13 -> rsp_misaligned=1.
6. SB in flight, RSTn=0 during WR -> MemWrite=0 immediately, RAM[4] unchanged.
   - After RSTn=1: req_ready=1, a following LW 0x10 completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit bridging the core data port to a word-organised RAM.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misaligned,
  output logic              rsp_error,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RSP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [31:0]       write_data_q, write_data_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_mis_q, rsp_mis_d;
  logic              rsp_err_q, rsp_err_d;

  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] rd_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] st_merged;

  // Word-address bits above ADDR_W+1 wrap and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    req_illegal = 1'b0;
    if (req_we) begin
      req_illegal = (req_funct3[2] == 1'b1) || (req_funct3[1:0] == 2'b11);
    end else begin
      req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    end
  end

  always_comb begin
    unique case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    rd_shifted = read_data >> {addr_lo_q, 3'b000};
    ld_byte    = rd_shifted[7:0];
    ld_half    = addr_lo_q[1] ? read_data[31:16] : read_data[15:0];
    unique case (funct3_q[1:0])
      2'b00:   ld_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = read_data;
    endcase
  end

  always_comb begin
    st_merged = read_data;
    if (funct3_q[1:0] == 2'b00) begin
      st_merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      st_merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_mis_d    = rsp_mis_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata[15:0];
          address_d = req_addr[ADDR_W+1:2];
          if (req_illegal || req_misaligned) begin
            // Error outranks misalignment; neither touches the RAM.
            rsp_err_d   = req_illegal;
            rsp_mis_d   = ~req_illegal;
            rsp_rdata_d = 32'd0;
            state_d     = RSP;
          end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
            write_data_d = req_wdata;
            state_d      = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          write_data_d = st_merged;
          state_d      = WR;
        end else begin
          rsp_rdata_d = ld_ext;
          rsp_mis_d   = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end
      end
      WR: begin
        rsp_rdata_d = 32'd0;
        rsp_mis_d   = 1'b0;
        rsp_err_d   = 1'b0;
        state_d     = RSP;
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      wdata_q      <= 16'd0;
      address_q    <= '0;
      write_data_q <= 32'd0;
      rsp_rdata_q  <= 32'd0;
      rsp_mis_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_mis_q    <= rsp_mis_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Strobes decode straight from state so a reset kills them at once.
  assign req_ready      = (state_q == IDLE);
  assign MemRead        = (state_q == RD);
  assign MemWrite       = (state_q == WR);
  assign rsp_valid      = (state_q == RSP);
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_misaligned = rsp_mis_q;
  assign rsp_error      = rsp_err_q;
  assign address        = address_q;
  assign write_data     = write_data_q;

endmodule
